// File: rtl/st7789_frame_feeder_pkg.sv
// Shared definitions for the ST7789 frame feeder: controller opcodes,
// RGB565 colour constants, FSM state encoding and a colour-select helper.
package st7789_frame_feeder_pkg;

  localparam logic [7:0] ST7789_CASET = 8'h2A;
  localparam logic [7:0] ST7789_RASET = 8'h2B;
  localparam logic [7:0] ST7789_RAMWR = 8'h2C;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_WAIT,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_DONE
  } state_t;

  function automatic logic [15:0] pick_colour(input logic pix, input logic [15:0] fg,
                                              input logic [15:0] bg);
    return pix ? fg : bg;
  endfunction

endpackage

// File: rtl/st7789_frame_feeder.sv
// Byte source for the ST7789 serializer: address-window preamble followed by
// one frame of RGB565 pixels expanded from a 1bpp framebuffer.
module st7789_frame_feeder
  import st7789_frame_feeder_pkg::*;
#(
  parameter int unsigned SRC_W  = 128,
  parameter int unsigned SRC_H  = 64,
  parameter int unsigned X0     = 56,
  parameter int unsigned Y0     = 88,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       fg_colour,
  input  logic [15:0]       bg_colour,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic [7:0]        out_byte,
  output logic              out_dc,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [15:0] X0_16 = 16'(X0);
  localparam logic [15:0] Y0_16 = 16'(Y0);
  localparam logic [15:0] XE_16 = 16'(X0 + SRC_W - 1);
  localparam logic [15:0] YE_16 = 16'(Y0 + SRC_H - 1);
  localparam int unsigned NBYTES = SRC_W * SRC_H / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBYTES - 1);

  state_t              state_q;
  logic [3:0]          hdr_idx_q;
  logic [15:0]         fg_q, bg_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          shift_q;
  logic [2:0]          bit_q;
  logic                busy_q, done_q;
  logic [7:0]          out_byte_q;
  logic                out_dc_q, out_valid_q;

  logic                xfer;
  logic [15:0]         first_colour, cur_colour, next_colour;

  // Header ROM entry as {dc, byte}
  function automatic logic [8:0] hdr_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_rom = {1'b0, ST7789_CASET};
      4'd1:    hdr_rom = {1'b1, X0_16[15:8]};
      4'd2:    hdr_rom = {1'b1, X0_16[7:0]};
      4'd3:    hdr_rom = {1'b1, XE_16[15:8]};
      4'd4:    hdr_rom = {1'b1, XE_16[7:0]};
      4'd5:    hdr_rom = {1'b0, ST7789_RASET};
      4'd6:    hdr_rom = {1'b1, Y0_16[15:8]};
      4'd7:    hdr_rom = {1'b1, Y0_16[7:0]};
      4'd8:    hdr_rom = {1'b1, YE_16[15:8]};
      4'd9:    hdr_rom = {1'b1, YE_16[7:0]};
      default: hdr_rom = {1'b0, ST7789_RAMWR};
    endcase
  endfunction

  assign xfer         = out_valid_q && out_ready;
  assign first_colour = pick_colour(fb_data[7], fg_q, bg_q);
  assign cur_colour   = pick_colour(shift_q[7], fg_q, bg_q);
  assign next_colour  = pick_colour(shift_q[6], fg_q, bg_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hdr_idx_q   <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_byte_q  <= '0;
      out_dc_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          // done_q still high here means start coincides with frame_done
          if (start && !done_q) begin
            busy_q                 <= 1'b1;
            fg_q                   <= fg_colour;
            bg_q                   <= bg_colour;
            addr_q                 <= '0;
            hdr_idx_q              <= '0;
            {out_dc_q, out_byte_q} <= hdr_rom(4'd0);
            out_valid_q            <= 1'b1;
            state_q                <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (xfer) begin
            if (hdr_idx_q == 4'd10) begin
              out_valid_q <= 1'b0;
              state_q     <= ST_FETCH;
            end else begin
              hdr_idx_q              <= hdr_idx_q + 4'd1;
              {out_dc_q, out_byte_q} <= hdr_rom(hdr_idx_q + 4'd1);
            end
          end
        end
        ST_FETCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          shift_q     <= fb_data;
          bit_q       <= '0;
          out_byte_q  <= first_colour[15:8];
          out_dc_q    <= 1'b1;
          out_valid_q <= 1'b1;
          state_q     <= ST_PIX_HI;
        end
        ST_PIX_HI: begin
          if (xfer) begin
            out_byte_q <= cur_colour[7:0];
            state_q    <= ST_PIX_LO;
          end
        end
        ST_PIX_LO: begin
          if (xfer) begin
            if (bit_q == 3'd7) begin
              out_valid_q <= 1'b0;
              if (addr_q == LAST_ADDR) begin
                state_q <= ST_DONE;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= ST_FETCH;
              end
            end else begin
              bit_q      <= bit_q + 3'd1;
              shift_q    <= {shift_q[6:0], 1'b0};
              out_byte_q <= next_colour[15:8];
              state_q    <= ST_PIX_HI;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign fb_addr    = addr_q;
  assign out_byte   = out_byte_q;
  assign out_dc     = out_dc_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_st7789_frame_feeder.sv
// Directed bench for st7789_frame_feeder: header contents, pixel expansion,
// full frames with and without backpressure, restart and mid-frame reset.
module tb_st7789_frame_feeder;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] fg_colour, bg_colour;
  logic        busy, frame_done;
  logic [9:0]  fb_addr;
  logic [7:0]  fb_data, out_byte;
  logic        out_dc, out_valid, out_ready;

  logic [7:0]  mem [1024];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_bad = 0;
  int unstable = 0;
  bit stall_prev = 1'b0;
  bit sod = 1'b0;
  logic [7:0] prev_b;
  logic       prev_dc;

  logic [7:0] q_b[$];
  logic       q_dc[$];
  logic [9:0] q_a[$];

  logic [7:0] hdr_b [11] = '{8'h2A, 8'h00, 8'h38, 8'h00, 8'hB7, 8'h2B,
                             8'h00, 8'h58, 8'h00, 8'h97, 8'h2C};
  logic       hdr_dc [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  // fb byte A0 = 1010_0000 with fg F800 / bg 001F
  logic [7:0] px_a0 [16] = '{8'hF8, 8'h00, 8'h00, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F,
                             8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00, 8'h1F};

  always #5 clk = ~clk;
  always @(posedge clk) fb_data <= mem[fb_addr];

  st7789_frame_feeder #(
    .SRC_W (128),
    .SRC_H (64),
    .X0    (56),
    .Y0    (88),
    .ADDR_W(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .fg_colour (fg_colour),
    .bg_colour (bg_colour),
    .busy      (busy),
    .frame_done(frame_done),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .out_byte  (out_byte),
    .out_dc    (out_dc),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit rnd, input bit st);
    @(negedge clk);
    if (stall_prev && !(out_valid === 1'b1 && out_byte === prev_b && out_dc === prev_dc))
      unstable++;
    if (frame_done) begin
      done_cnt++;
      if (busy) busy_bad++;
    end
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start     = st | (sod & frame_done);
    if (out_valid && out_ready) begin
      q_b.push_back(out_byte);
      q_dc.push_back(out_dc);
      q_a.push_back(fb_addr);
    end
    stall_prev = out_valid && !out_ready;
    prev_b     = out_byte;
    prev_dc    = out_dc;
  endtask

  task automatic clear_q();
    q_b.delete();
    q_dc.delete();
    q_a.delete();
  endtask

  task automatic check_stream(input string tag, input logic [15:0] fgv);
    int bad = 0;
    logic [7:0] eb;
    logic       ed;
    chk({tag, "_count"}, q_b.size(), 32'd16395);
    for (int k = 0; k < q_b.size(); k++) begin
      if (k < 11) begin
        eb = hdr_b[k];
        ed = hdr_dc[k];
      end else begin
        eb = ((k - 11) % 2 == 0) ? fgv[15:8] : fgv[7:0];
        ed = 1'b1;
      end
      if (q_b[k] !== eb || q_dc[k] !== ed) bad++;
    end
    chk({tag, "_bytes_bad"}, bad, 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    fg_colour = 16'hF800;
    bg_colour = 16'h001F;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 0);
    chk("rst_dc", out_dc, 0);
    chk("rst_addr", fb_addr, 0);
    reset = 1'b0;

    // Frame A: full rate, all-ones framebuffer, restart attempt mid-frame
    // with new colours, and a start coincident with frame_done
    sod = 1'b1;
    clear_q();
    cycle(0, 1);
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      if (n == 100) begin
        fg_colour = 16'h07E0;
        bg_colour = 16'hFFFF;
      end
      cycle(0, n == 100);
      if (n == 50) chk("busy_mid", busy, 1);
      n++;
    end
    chk("frameA_done_seen", done_cnt, 1);
    sod = 1'b0;
    repeat (3) cycle(0, 0);
    chk("frameA_done_single", done_cnt, 1);
    chk("frameA_busy_with_done", busy_bad, 0);
    chk("coincident_start_busy", busy, 0);
    chk("coincident_start_valid", out_valid, 0);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("hdr_byte%0d", k), q_b[k], hdr_b[k]);
      chk($sformatf("hdr_dc%0d", k), q_dc[k], hdr_dc[k]);
    end
    check_stream("frameA", 16'hF800);

    // Frame B: random backpressure, identical stream expected
    fg_colour = 16'hF800;
    bg_colour = 16'h001F;
    clear_q();
    cycle(1, 1);
    n = 0;
    while (done_cnt == 1 && n < 40000) begin
      cycle(1, 0);
      n++;
    end
    chk("frameB_done_seen", done_cnt, 2);
    chk("frameB_replay_first", q_b[0], 8'h2A);
    check_stream("frameB", 16'hF800);
    chk("frameB_stall_stable", unstable, 0);
    chk("frameB_busy_with_done", busy_bad, 0);

    // Frame C: pixel expansion of A0, then reset at transfer 500
    mem[0] = 8'hA0;
    clear_q();
    cycle(0, 1);
    n = 0;
    while (q_b.size() < 500 && n < 2000) begin
      cycle(0, 0);
      n++;
    end
    chk("frameC_reach_500", q_b.size(), 500);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", frame_done, 0);
    reset      = 1'b0;
    stall_prev = 1'b0;
    bad = 0;
    for (int k = 0; k < 16; k++) if (q_b[11 + k] !== px_a0[k]) bad++;
    chk("a0_pixels_bad", bad, 0);
    chk("a0_addr_first", q_a[11], 0);
    chk("a0_addr_last", q_a[26], 0);
    chk("a0_addr_next", q_a[27], 1);
    repeat (4) cycle(0, 0);
    chk("midrst_no_done", done_cnt, 2);
    chk("midrst_idle_valid", out_valid, 0);

    // Restart after reset: header from the top, address back at 0
    clear_q();
    cycle(0, 1);
    n = 0;
    while (q_b.size() < 12 && n < 100) begin
      cycle(0, 0);
      n++;
    end
    chk("restart_first_byte", q_b[0], 8'h2A);
    chk("restart_first_dc", q_dc[0], 0);
    chk("restart_pix_addr", q_a[11], 0);
    chk("restart_pix_byte", q_b[11], 8'hF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
